// File: rtl/system_reg_bank.sv
// rtl/system_reg_bank.sv - parametrised system register bank with byte-strobed system port and hardware update channels
module system_reg_bank #(
  parameter int                 ENTRIES    = 12,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 HW_PORTS   = 2,
  parameter logic [ENTRIES-1:0] RO_MASK    = '0,
  parameter logic [ENTRIES-1:0] W1C_MASK   = '0,
  localparam int                ADDR_WIDTH = $clog2(ENTRIES),
  localparam int                BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           system_reg_en,
  input  logic                           system_reg_we,
  input  logic [ADDR_WIDTH-1:0]          system_reg_addr,
  input  logic [BE_WIDTH-1:0]            system_reg_be,
  input  logic [DATA_WIDTH-1:0]          system_reg_din,
  output logic [DATA_WIDTH-1:0]          system_reg_dout,
  output logic                           system_reg_valid,
  output logic                           system_reg_err,
  input  logic [HW_PORTS-1:0]            hw_we,
  input  logic [HW_PORTS*ADDR_WIDTH-1:0] hw_addr,
  input  logic [HW_PORTS*DATA_WIDTH-1:0] hw_din,
  output logic [DATA_WIDTH-1:0]          reg_values [ENTRIES],
  output logic [ENTRIES-1:0]             reg_changed
);

  logic [DATA_WIDTH-1:0] regs     [ENTRIES];
  logic [DATA_WIDTH-1:0] regs_nxt [ENTRIES];
  logic [DATA_WIDTH-1:0] be_mask;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  addr_ok;
  logic                  ro_hit;
  logic                  hw_hit;
  logic                  sys_wr;
  logic [DATA_WIDTH-1:0] hw_word;
  logic [DATA_WIDTH-1:0] hw_set;

  assign reg_values = regs;

  // Decode the system access: byte mask, range check, read mux and read-only lookup
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      be_mask[b*8 +: 8] = {8{system_reg_be[b]}};
    end
    addr_ok = int'(system_reg_addr) < ENTRIES;
    rd_data = '0;
    ro_hit  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (system_reg_addr == ADDR_WIDTH'(i)) begin
        rd_data = regs[i];
        ro_hit  = RO_MASK[i];
      end
    end
  end

  // Next value per register: system write vs hardware update, with W1C set-wins merging
  always_comb begin
    hw_hit  = 1'b0;
    hw_word = '0;
    hw_set  = '0;
    sys_wr  = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      hw_hit  = 1'b0;
      hw_word = '0;
      hw_set  = '0;
      // Descending scan so the lowest-index channel is the last to overwrite hw_word
      for (int k = HW_PORTS - 1; k >= 0; k--) begin
        if (hw_we[k] && hw_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
          hw_hit  = 1'b1;
          hw_word = hw_din[k*DATA_WIDTH +: DATA_WIDTH];
          hw_set  = hw_set | hw_din[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      sys_wr = system_reg_en && system_reg_we && !RO_MASK[i] &&
               (system_reg_addr == ADDR_WIDTH'(i));
      regs_nxt[i] = regs[i];
      if (W1C_MASK[i]) begin
        regs_nxt[i] = (regs[i] & ~(sys_wr ? (system_reg_din & be_mask) : '0)) | hw_set;
      end else if (sys_wr) begin
        regs_nxt[i] = (regs[i] & ~be_mask) | (system_reg_din & be_mask);
      end else if (hw_hit) begin
        regs_nxt[i] = hw_word;
      end
    end
  end

  // Register state, change pulses and the one-cycle access response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        regs[i] <= '0;
      end
      reg_changed      <= '0;
      system_reg_dout  <= '0;
      system_reg_valid <= 1'b0;
      system_reg_err   <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        regs[i]        <= regs_nxt[i];
        reg_changed[i] <= regs_nxt[i] != regs[i];
      end
      system_reg_valid <= system_reg_en;
      system_reg_err   <= system_reg_en && (!addr_ok || (system_reg_we && ro_hit));
      if (system_reg_en && !system_reg_we) begin
        system_reg_dout <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_system_reg_bank.sv
// tb/tb_system_reg_bank.sv - self-checking bench for system_reg_bank
module tb_system_reg_bank;

  localparam int          N   = 12;
  localparam logic [11:0] RO  = 12'h020;
  localparam logic [11:0] W1C = 12'h080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [3:0]  be = '0;
  logic [31:0] din = '0;
  logic [1:0]  hw_we = '0;
  logic [7:0]  hw_addr = '0;
  logic [63:0] hw_din = '0;
  logic [31:0] dout;
  logic        valid;
  logic        err;
  logic [31:0] reg_values [N];
  logic [11:0] reg_changed;

  int n_vec = 0;
  int miss  = 0;

  system_reg_bank #(
    .ENTRIES(N), .DATA_WIDTH(32), .HW_PORTS(2), .RO_MASK(RO), .W1C_MASK(W1C)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .system_reg_en(en), .system_reg_we(we), .system_reg_addr(addr),
    .system_reg_be(be), .system_reg_din(din),
    .system_reg_dout(dout), .system_reg_valid(valid), .system_reg_err(err),
    .hw_we(hw_we), .hw_addr(hw_addr), .hw_din(hw_din),
    .reg_values(reg_values), .reg_changed(reg_changed)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_regs [N];
  logic [31:0] exp_dout;
  logic        exp_valid;
  logic        exp_err;
  logic [11:0] exp_changed;
  bit          started = 0;

  // Model update: apply the access and hardware rules once per rising edge
  always @(posedge clk) begin
    logic [31:0] old [N];
    logic [31:0] nv;
    logic [31:0] bm;
    logic [31:0] setv;
    int a;
    bit found;
    started = 1;
    if (!rst_n) begin
      for (int r = 0; r < N; r++) m_regs[r] = '0;
      exp_dout = '0; exp_valid = 0; exp_err = 0; exp_changed = '0;
    end else begin
      old = m_regs;
      a = int'(addr);
      bm = '0;
      for (int b = 0; b < 4; b++) if (be[b]) bm[b*8 +: 8] = 8'hFF;
      exp_valid = en;
      exp_err = en && ((a >= N) ? 1'b1 : (we && RO[a]));
      if (en && !we) exp_dout = (a < N) ? old[a] : 32'h0;
      for (int r = 0; r < N; r++) begin
        nv = old[r];
        if (W1C[r]) begin
          setv = '0;
          for (int k = 0; k < 2; k++)
            if (hw_we[k] && int'(hw_addr[k*4 +: 4]) == r) setv = setv | hw_din[k*32 +: 32];
          if (en && we && a == r) nv = nv & ~(din & bm);
          nv = nv | setv;
        end else if (en && we && a == r && !RO[r]) begin
          for (int b = 0; b < 4; b++) if (be[b]) nv[b*8 +: 8] = din[b*8 +: 8];
        end else begin
          found = 0;
          for (int k = 0; k < 2; k++)
            if (!found && hw_we[k] && int'(hw_addr[k*4 +: 4]) == r) begin
              nv = hw_din[k*32 +: 32];
              found = 1;
            end
        end
        m_regs[r] = nv;
        exp_changed[r] = (nv != old[r]);
      end
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    if (started) begin
      n_vec++;
      if (valid !== exp_valid || err !== exp_err || dout !== exp_dout || reg_changed !== exp_changed) begin
        miss++;
        $display("FAIL resp t=%0t: valid=%b err=%b dout=%h chg=%h, expected valid=%b err=%b dout=%h chg=%h",
                 $time, valid, err, dout, reg_changed, exp_valid, exp_err, exp_dout, exp_changed);
      end
      for (int r = 0; r < N; r++) begin
        n_vec++;
        if (reg_values[r] !== m_regs[r]) begin
          miss++;
          $display("FAIL reg_values[%0d] t=%0t: got %h expected %h", r, $time, reg_values[r], m_regs[r]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic e, input logic w, input logic [3:0] a, input logic [3:0] bb,
                     input logic [31:0] d, input logic [1:0] hwe,
                     input logic [3:0] a0, input logic [31:0] d0,
                     input logic [3:0] a1, input logic [31:0] d1);
    en = e; we = w; addr = a; be = bb; din = d;
    hw_we = hwe; hw_addr = {a1, a0}; hw_din = {d1, d0};
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 4'd0, 4'h0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_valid", {31'b0, valid}, 32'h0);
    chk("reset_reg0", reg_values[0], 32'h0);

    drv(1, 0, 4'd0, 4'h0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("read0_valid", {31'b0, valid}, 32'h1);
    chk("read0_err", {31'b0, err}, 32'h0);
    chk("read0_dout", dout, 32'h0);

    drv(1, 1, 4'd3, 4'hF, 32'h11223344, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    drv(1, 1, 4'd3, 4'h5, 32'hAABBCCDD, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("be_merge", reg_values[3], 32'h11BB33DD);
    chk("changed3", {31'b0, reg_changed[3]}, 32'h1);
    drv(1, 0, 4'd3, 4'h0, 32'h0, 2'b01, 4'd3, 32'h00000055, 4'd0, 32'h0);
    chk("rbw_dout", dout, 32'h11BB33DD);
    chk("hw_reg3", reg_values[3], 32'h00000055);
    idle();
    chk("changed3_clear", {31'b0, reg_changed[3]}, 32'h0);

    drv(0, 0, 4'd0, 4'h0, 32'h0, 2'b01, 4'd5, 32'h0000BEEF, 4'd0, 32'h0);
    drv(1, 1, 4'd5, 4'hF, 32'hFFFFFFFF, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("ro_keep", reg_values[5], 32'h0000BEEF);
    chk("ro_err", {30'b0, valid, err}, 32'h3);
    drv(1, 0, 4'd12, 4'h0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("oor_dout", dout, 32'h0);
    chk("oor_err", {31'b0, err}, 32'h1);

    drv(0, 0, 4'd0, 4'h0, 32'h0, 2'b10, 4'd0, 32'h0, 4'd7, 32'h0000000F);
    drv(1, 1, 4'd7, 4'hF, 32'h00000003, 2'b10, 4'd0, 32'h0, 4'd7, 32'h00000001);
    chk("w1c_setwins", reg_values[7], 32'h0000000D);
    chk("w1c_err", {31'b0, err}, 32'h0);
    drv(1, 1, 4'd7, 4'h0, 32'hFFFFFFFF, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("w1c_no_be", reg_values[7], 32'h0000000D);

    drv(0, 0, 4'd0, 4'h0, 32'h0, 2'b11, 4'd2, 32'h1, 4'd2, 32'h2);
    chk("hw_lowest_wins", reg_values[2], 32'h1);
    drv(1, 1, 4'd2, 4'hF, 32'h3, 2'b11, 4'd2, 32'h1, 4'd2, 32'h2);
    chk("sys_over_hw", reg_values[2], 32'h3);
    drv(1, 1, 4'd2, 4'hF, 32'h3, 2'b11, 4'd13, 32'hDEAD, 4'd14, 32'hBEEF);
    chk("same_data_nochg", {20'b0, reg_changed}, 32'h0);

    for (int i = 0; i < N; i++) drv(1, 1, 4'(i), 4'hF, 32'h01010101 * i, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("w1c_clear7", reg_values[7], 32'h00000008);
    for (int i = 0; i < 16; i++) drv(1, 0, 4'(i), 4'h0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("last_oor_dout", dout, 32'h0);

    drv(1, 0, 4'd3, 4'h0, 32'h0, 2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
    chk("pre_rst_valid", {31'b0, valid}, 32'h1);
    rst_n = 1'b0;
    drv(1, 0, 4'd3, 4'h0, 32'h0, 2'b01, 4'd4, 32'h1234, 4'd0, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_reg3", reg_values[3], 32'h0);
    chk("rst_reg4", reg_values[4], 32'h0);
    rst_n = 1'b1;
    idle();
    chk("post_rst_valid", {31'b0, valid}, 32'h0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end

endmodule
